// File: rtl/conv_strip_if.sv
// Pixel-fetch and result-stream signals of the strip convolution engine.
// The master side is the engine; the slave side is the BRAM and result consumer.
interface conv_strip_if #(
  parameter int DATA_W = 9,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 16
);
  logic        [ADDR_W-1:0] fm_addr;
  logic signed [DATA_W-1:0] fm_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;

  modport master (
    output fm_addr, out_valid, out_data, out_last,
    input  fm_rdata, out_ready
  );

  modport slave (
    input  fm_addr, out_valid, out_data, out_last,
    output fm_rdata, out_ready
  );
endinterface

// File: rtl/conv_strip_engine.sv
// KxK signed convolution over one strip: one tap fetched per cycle, a sequential MAC,
// optional ReLU plus saturation, and results streamed over a valid/ready port.
module conv_strip_engine #(
  parameter int K      = 3,
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 30,
  parameter int STRIDE = 1,
  parameter int DATA_W = 9,
  parameter int KER_W  = 9,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    k_we,
  input  logic [5:0]              k_idx,
  input  logic signed [KER_W-1:0] k_data,
  input  logic                    start,
  input  logic                    relu_en,
  conv_strip_if.master            bus,
  output logic                    busy,
  output logic                    done
);

  localparam int OW     = (IMG_W - K) / STRIDE + 1;
  localparam int OH     = (IMG_H - K) / STRIDE + 1;
  localparam int PROD_W = DATA_W + KER_W;
  localparam logic [5:0] LAST_TAP = 6'(K * K - 1);
  localparam logic [5:0] LAST_KX  = 6'(K - 1);
  localparam logic [5:0] NUM_TAPS = 6'(K * K);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] TAP_ROW  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_OX  = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] LAST_OY  = ADDR_W'(OH - 1);
  localparam longint SMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SMAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SMAX - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  state_t state, next_state;

  logic signed [KER_W-1:0]  coeff [64];
  logic        [5:0]        tap, kx, mac_idx;
  logic                     mac_en, relu_q, last_win;
  logic        [ADDR_W-1:0] row_off, row_base, col_base, ox, oy;
  logic signed [ACC_W-1:0]  acc, prod_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  sat;

  // Coefficients survive reset so a restarted strip reuses the loaded kernel.
  always_ff @(posedge clk) begin
    if (state == IDLE && k_we && k_idx < NUM_TAPS)
      coeff[k_idx] <= k_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = FETCH;
      FETCH: if (tap == LAST_TAP) next_state = DRAIN;
      DRAIN: next_state = OUT;
      OUT:   if (bus.out_ready) next_state = last_win ? DONE : FETCH;
      DONE:  next_state = IDLE;
    endcase
  end

  assign last_win = (ox == LAST_OX) && (oy == LAST_OY);
  assign prod     = bus.fm_rdata * coeff[mac_idx];
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Tap data returns one cycle after its address, so the MAC runs one step behind FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap      <= '0;
      kx       <= '0;
      row_off  <= '0;
      row_base <= '0;
      col_base <= '0;
      ox       <= '0;
      oy       <= '0;
      acc      <= '0;
      mac_en   <= 1'b0;
      mac_idx  <= '0;
      relu_q   <= 1'b0;
    end else begin
      mac_en  <= (state == FETCH);
      mac_idx <= tap;
      if (state == FETCH && tap == '0) acc <= '0;
      else if (mac_en)                 acc <= acc + prod_ext;
      case (state)
        IDLE: if (start) begin
          relu_q   <= relu_en;
          tap      <= '0;
          kx       <= '0;
          row_off  <= '0;
          row_base <= '0;
          col_base <= '0;
          ox       <= '0;
          oy       <= '0;
        end
        FETCH: if (tap == LAST_TAP) begin
          tap     <= '0;
          kx      <= '0;
          row_off <= '0;
        end else begin
          tap <= tap + 6'd1;
          if (kx == LAST_KX) begin
            kx      <= '0;
            row_off <= row_off + TAP_ROW;
          end else begin
            kx <= kx + 6'd1;
          end
        end
        OUT: if (bus.out_ready && !last_win) begin
          if (ox == LAST_OX) begin
            ox       <= '0;
            col_base <= '0;
            oy       <= oy + 1'b1;
            row_base <= row_base + ROW_STEP;
          end else begin
            ox       <= ox + 1'b1;
            col_base <= col_base + COL_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sat = acc[OUT_W-1:0];
    if (relu_q && acc < 0)  sat = '0;
    else if (acc > SAT_MAX) sat = SAT_MAX[OUT_W-1:0];
    else if (acc < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
  end

  assign bus.fm_addr   = row_base + col_base + row_off + ADDR_W'(kx);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = sat;
  assign bus.out_last  = (state == OUT) && last_win;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_conv_strip_engine.sv
// Directed bench: a 5x4 stride-1 engine and a 7x7 stride-2 engine, each fed by a
// synchronous pixel memory model, checked against hand-computed window results.
module tb_conv_strip_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, k_we, start_a, start_b, relu_en;
  logic [5:0]        k_idx;
  logic signed [8:0] k_data;
  logic              busy_a, done_a, busy_b, done_b;

  conv_strip_if #(.DATA_W(9), .OUT_W(16), .ADDR_W(16)) bus_a ();
  conv_strip_if #(.DATA_W(9), .OUT_W(16), .ADDR_W(16)) bus_b ();

  conv_strip_engine #(.K(3), .IMG_W(5), .IMG_H(4), .STRIDE(1), .DATA_W(9), .KER_W(9),
                      .ACC_W(32), .OUT_W(16), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(reset), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .start(start_a), .relu_en(relu_en), .bus(bus_a), .busy(busy_a), .done(done_a)
  );

  conv_strip_engine #(.K(3), .IMG_W(7), .IMG_H(7), .STRIDE(2), .DATA_W(9), .KER_W(9),
                      .ACC_W(32), .OUT_W(16), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(reset), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .start(start_b), .relu_en(relu_en), .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  logic signed [8:0] mem_a [65536];
  logic signed [8:0] mem_b [65536];

  always @(posedge clk) begin
    bus_a.fm_rdata <= mem_a[bus_a.fm_addr];
    bus_b.fm_rdata <= mem_b[bus_b.fm_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_data [16];
  int res_data [16];
  int res_last [16];
  int nres;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic signed [8:0] val);
    @(negedge clk);
    k_we   = 1'b1;
    k_idx  = idx;
    k_data = val;
    @(negedge clk);
    k_we   = 1'b0;
  endtask

  task automatic loadKernel(input bit centre_only, input logic signed [8:0] val);
    for (int i = 0; i < 9; i++)
      applyStimulus(6'(i), (centre_only && i != 4) ? 9'sd0 : val);
  endtask

  // Runs one strip on the selected engine; bp stalls the consumer on the 2nd window.
  task automatic runStrip(input bit sel, input int n_exp, input bit bp);
    int   cycles, stall, addr_changes;
    bit   fin, v, rdy;
    logic [15:0] addr, prev_addr;
    nres = 0; fin = 0; stall = 0; addr_changes = 0; cycles = 0; prev_addr = '0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    checkOutput("busy_after_start", sel ? busy_b : busy_a, 1);
    if (sel) begin
      for (int t = 0; t < 9; t++) begin
        checkOutput($sformatf("stride_addr_tap%0d", t), bus_b.fm_addr, (t / 3) * 7 + t % 3);
        @(negedge clk);
      end
    end
    while (!fin && cycles < 1000) begin
      v    = sel ? bus_b.out_valid : bus_a.out_valid;
      addr = sel ? bus_b.fm_addr : bus_a.fm_addr;
      rdy  = 1'b1;
      if (bp && v && nres == 1 && stall < 10) begin
        rdy = 1'b0;
        if (stall > 0 && addr != prev_addr) addr_changes++;
        checkOutput("bp_data_hold", bus_a.out_data, exp_data[1]);
        stall++;
      end
      prev_addr = addr;
      if (sel) bus_b.out_ready = rdy; else bus_a.out_ready = rdy;
      if (v && rdy && nres < 16) begin
        res_data[nres] = sel ? bus_b.out_data : bus_a.out_data;
        res_last[nres] = sel ? bus_b.out_last : bus_a.out_last;
        nres++;
      end
      if (sel ? done_b : done_a) fin = 1'b1;
      @(negedge clk);
      cycles++;
    end
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    checkOutput("done_seen", fin, 1);
    checkOutput("done_single_pulse", sel ? done_b : done_a, 0);
    checkOutput("idle_after_done", sel ? busy_b : busy_a, 0);
    if (bp) begin
      checkOutput("bp_addr_changes", addr_changes, 0);
      checkOutput("bp_stall_cycles", stall, 10);
    end
    checkOutput("result_count", nres, n_exp);
    for (int i = 0; i < n_exp && i < nres; i++) begin
      checkOutput($sformatf("result%0d", i), res_data[i], exp_data[i]);
      checkOutput($sformatf("last%0d", i), res_last[i], (i == n_exp - 1) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1; k_we = 1'b0; k_idx = '0; k_data = '0;
    start_a = 1'b0; start_b = 1'b0; relu_en = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_fm_addr", bus_a.fm_addr, 0);
    checkOutput("rst_out_valid", bus_a.out_valid, 0);
    checkOutput("rst_out_data", bus_a.out_data, 0);
    checkOutput("rst_out_last", bus_a.out_last, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    reset = 1'b0;

    $display("[TB] all-ones pixels and kernel");
    for (int i = 0; i < 20; i++) mem_a[i] = 9'sd1;
    loadKernel(1'b0, 9'sd1);
    for (int i = 0; i < 6; i++) exp_data[i] = 9;
    runStrip(1'b0, 6, 1'b0);

    $display("[TB] identity kernel with backpressure");
    for (int i = 0; i < 20; i++) mem_a[i] = 9'(i);
    loadKernel(1'b1, 9'sd1);
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 3; ox++) exp_data[oy * 3 + ox] = (oy + 1) * 5 + ox + 1;
    runStrip(1'b0, 6, 1'b1);

    $display("[TB] saturation and relu");
    for (int i = 0; i < 20; i++) mem_a[i] = 9'sd255;
    loadKernel(1'b0, 9'sd255);
    for (int i = 0; i < 6; i++) exp_data[i] = 32767;
    runStrip(1'b0, 6, 1'b0);
    loadKernel(1'b0, -9'sd255);
    relu_en = 1'b1;
    for (int i = 0; i < 6; i++) exp_data[i] = 0;
    runStrip(1'b0, 6, 1'b0);
    relu_en = 1'b0;
    for (int i = 0; i < 6; i++) exp_data[i] = -32768;
    runStrip(1'b0, 6, 1'b0);

    $display("[TB] stride 2 on 7x7");
    for (int i = 0; i < 49; i++) mem_b[i] = 9'(i);
    loadKernel(1'b1, 9'sd1);
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++) exp_data[oy * 3 + ox] = (2 * oy + 1) * 7 + 2 * ox + 1;
    runStrip(1'b1, 9, 1'b0);

    $display("[TB] reset during fetch then rerun");
    for (int i = 0; i < 20; i++) mem_a[i] = 9'(i);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", busy_a, 0);
    checkOutput("midrst_fm_addr", bus_a.fm_addr, 0);
    checkOutput("midrst_out_valid", bus_a.out_valid, 0);
    checkOutput("midrst_done", done_a, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 3; ox++) exp_data[oy * 3 + ox] = (oy + 1) * 5 + ox + 1;
    runStrip(1'b0, 6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
